// File: rtl/snake_move_scheduler.sv
// snake_move_scheduler: buffers direction buttons and issues one snake step per movement tick
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   btn_valid        one-cycle strobe qualifying btn_code
//   btn_code         0 none, 1 up, 2 down, 3 left, 4 right, 5 pause, 6-7 ignored
//   step_ack         game logic consumed the outstanding step
//   grow             one-cycle pulse when food is eaten
//   step_req         step request, held until acked
//   step_dir         direction of the outstanding step
//   dir_now          current direction (0 = stopped)
//   paused           high while paused
//   fifo_full        direction FIFO holds FIFO_DEPTH entries
//   overflow         sticky: a direction was dropped on a full FIFO
//   period_now       active tick period in clk cycles
//
// Build option: define SNAKE_ACCEL_EN to let grow shorten the tick period.
module snake_move_scheduler #(
    parameter int TICK_PERIOD  = 6000000,
    parameter int CNT_W        = 23,
    parameter int FIFO_DEPTH   = 4,
    parameter int SPEEDUP_STEP = 250000,
    parameter int MIN_PERIOD   = 1500000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_valid,
    input  logic [2:0]       btn_code,
    input  logic             step_ack,
    input  logic             grow,
    output logic             step_req,
    output logic [2:0]       step_dir,
    output logic [2:0]       dir_now,
    output logic             paused,
    output logic             fifo_full,
    output logic             overflow,
    output logic [CNT_W-1:0] period_now
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || MIN_PERIOD < 1 ||
        SPEEDUP_STEP < 1 || MIN_PERIOD > TICK_PERIOD) begin : g_bad_params
        $error("snake_move_scheduler: invalid parameter set");
    end

    typedef enum logic [1:0] {INIT, RUN, WAIT_ACK, PAUSED} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [AW:0]      count, count_next;
    logic             pause_pending;
    logic             is_dir, is_pause, tick, pop, accept_in, push, drop, turn;
    logic [2:0]       head, rev_now, next_dir;

    always_comb begin
        is_dir     = btn_valid && btn_code >= 3'd1 && btn_code <= 3'd4;
        is_pause   = btn_valid && btn_code == 3'd5;
        // >= rather than == so a grow that shrinks the period below the
        // running count still fires on the next cycle instead of wrapping.
        tick       = state == RUN && !is_pause && cnt >= period_now - CNT_W'(1);
        pop        = tick && count != '0;
        accept_in  = is_dir && (state == RUN || state == WAIT_ACK);
        // A pop in the same cycle frees a slot, so a full FIFO still accepts.
        push       = accept_in && (count != FULL || pop);
        drop       = accept_in && count == FULL && !pop;
        count_next = count + (AW+1)'(push) - (AW+1)'(pop);
        head       = mem[rd_ptr];
        rev_now    = dir_now == 3'd1 ? 3'd2 : dir_now == 3'd2 ? 3'd1 :
                     dir_now == 3'd3 ? 3'd4 : dir_now == 3'd4 ? 3'd3 : 3'd0;
        turn       = pop && head != dir_now && head != rev_now;
        next_dir   = turn ? head : dir_now;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= btn_code;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= INIT;
            cnt           <= '0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            pause_pending <= 1'b0;
            step_req      <= 1'b0;
            step_dir      <= 3'd0;
            dir_now       <= 3'd0;
            paused        <= 1'b0;
            fifo_full     <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count     <= count_next;
            fifo_full <= count_next == FULL;
            if (drop) overflow <= 1'b1;
            case (state)
                INIT: if (is_dir) begin
                    dir_now <= btn_code;
                    cnt     <= '0;
                    state   <= RUN;
                end
                RUN: if (is_pause) begin
                    paused <= 1'b1;
                    state  <= PAUSED;
                end else if (tick) begin
                    cnt      <= '0;
                    dir_now  <= next_dir;
                    step_dir <= next_dir;
                    step_req <= 1'b1;
                    state    <= WAIT_ACK;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
                WAIT_ACK: begin
                    cnt <= '0;
                    // A pause arriving with the ack still counts toward the toggle.
                    if (step_ack) begin
                        step_req      <= 1'b0;
                        pause_pending <= 1'b0;
                        paused        <= pause_pending ^ is_pause;
                        state         <= (pause_pending ^ is_pause) ? PAUSED : RUN;
                    end else if (is_pause) begin
                        pause_pending <= !pause_pending;
                    end
                end
                PAUSED: if (is_pause) begin
                    cnt    <= '0;
                    paused <= 1'b0;
                    state  <= RUN;
                end
            endcase
        end
    end

`ifdef SNAKE_ACCEL_EN
    localparam logic [CNT_W-1:0] FLOOR = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] STEP  = CNT_W'(SPEEDUP_STEP);

    always_ff @(posedge clk) begin
        if (reset) period_now <= CNT_W'(TICK_PERIOD);
        else if (grow && state != INIT) period_now <= (period_now < FLOOR + STEP) ? FLOOR : period_now - STEP;
    end
`else
    logic unused_grow;

    // Without acceleration the period is fixed and grow has no effect.
    assign unused_grow = grow;
    assign period_now  = CNT_W'(TICK_PERIOD);
`endif
endmodule

// File: tb/tb_snake_move_scheduler.sv
// tb_snake_move_scheduler: directed stimulus with a queue-based reference model checked every cycle
module tb_snake_move_scheduler;
    localparam int TP = 10;
    localparam int CW = 8;
    localparam int FD = 4;
    localparam int SS = 3;
    localparam int MP = 5;
`ifdef SNAKE_ACCEL_EN
    localparam bit ACCEL = 1'b1;
`else
    localparam bit ACCEL = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          btn_valid = 1'b0;
    logic [2:0]    btn_code = 3'd0;
    logic          step_ack = 1'b0;
    logic          grow = 1'b0;
    logic          step_req;
    logic [2:0]    step_dir;
    logic [2:0]    dir_now;
    logic          paused;
    logic          fifo_full;
    logic          overflow;
    logic [CW-1:0] period_now;

    int total = 0;
    int bad = 0;
    bit ack_en = 1'b1;
    int age = 0;

    always #5 clk = ~clk;

    snake_move_scheduler #(
        .TICK_PERIOD(TP), .CNT_W(CW), .FIFO_DEPTH(FD), .SPEEDUP_STEP(SS), .MIN_PERIOD(MP)
    ) dut (
        .clk(clk), .reset(reset), .btn_valid(btn_valid), .btn_code(btn_code),
        .step_ack(step_ack), .grow(grow), .step_req(step_req), .step_dir(step_dir),
        .dir_now(dir_now), .paused(paused), .fifo_full(fifo_full), .overflow(overflow),
        .period_now(period_now)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: game rules in terms of a direction queue and elapsed cycles.
    bit m_on = 1'b0;
    bit m_started, m_wait, m_pause, m_pend, m_req, m_ovf;
    int m_elapsed, m_period, m_dir, m_sdir;
    int m_q[$];

    function automatic int opposite(input int d);
        return (d % 2 == 1) ? d + 1 : d - 1;
    endfunction

    task automatic model_step();
        bit dirc, pz, was_started, enq;
        int h;
        dirc = btn_valid && btn_code inside {[3'd1:3'd4]};
        pz = btn_valid && btn_code == 3'd5;
        enq = 1'b0;
        if (reset) begin
            m_on = 1'b1;
            m_started = 0; m_wait = 0; m_pause = 0; m_pend = 0; m_req = 0; m_ovf = 0;
            m_elapsed = 0; m_period = TP; m_dir = 0; m_sdir = 0;
            m_q.delete();
            return;
        end
        was_started = m_started;
        if (!m_started) begin
            if (dirc) begin
                m_dir = int'(btn_code);
                m_started = 1;
                m_elapsed = 0;
            end
        end else if (m_pause) begin
            if (pz) begin
                m_pause = 0;
                m_elapsed = 0;
            end
        end else if (m_wait) begin
            enq = 1'b1;
            if (step_ack) begin
                m_req = 0;
                m_wait = 0;
                m_pause = m_pend != pz;
                m_pend = 0;
            end else if (pz) begin
                m_pend = !m_pend;
            end
        end else begin
            enq = 1'b1;
            if (pz) begin
                m_pause = 1;
            end else if (m_elapsed >= m_period - 1) begin
                if (m_q.size() > 0) begin
                    h = m_q.pop_front();
                    if (h != m_dir && h != opposite(m_dir)) m_dir = h;
                end
                m_req = 1;
                m_sdir = m_dir;
                m_wait = 1;
                m_elapsed = 0;
            end else begin
                m_elapsed++;
            end
        end
        if (enq && dirc) begin
            if (m_q.size() < FD) m_q.push_back(int'(btn_code));
            else m_ovf = 1;
        end
        if (ACCEL && grow && was_started) m_period = (m_period - SS < MP) ? MP : m_period - SS;
    endtask

    initial forever begin
        @(negedge clk);
        if (m_on) begin
            chk("step_req", step_req, m_req);
            chk("step_dir", step_dir, m_sdir);
            chk("dir_now", dir_now, m_dir);
            chk("paused", paused, m_pause);
            chk("fifo_full", fifo_full, m_q.size() == FD);
            chk("overflow", overflow, m_ovf);
            chk("period_now", period_now, m_period);
        end
        model_step();
    end

    // Game-logic responder: acks two cycles after step_req rises while enabled.
    initial forever begin
        @(posedge clk);
        #2;
        if (reset || step_req !== 1'b1) age = 0;
        else if (ack_en) age++;
        step_ack = ack_en && age == 2;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [2:0] c);
        btn_valid = 1'b1;
        btn_code = c;
        cyc(1);
        btn_valid = 1'b0;
        btn_code = 3'd0;
    endtask

    task automatic pulse_grow();
        grow = 1'b1;
        cyc(1);
        grow = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
    endtask

    task automatic wait_req(output int n, input logic level, input int limit);
        n = 0;
        while (step_req !== level && n < limit) begin
            cyc(1);
            n++;
        end
    endtask

    task automatic quiet(output int seen, input int cycles);
        seen = 0;
        repeat (cycles) begin
            if (step_req !== 1'b0) seen++;
            cyc(1);
        end
    endtask

    initial begin
        int n;
        do_reset();
        // Start, first step timing and handshake
        press(3'd4);
        chk("t1_dir_now", dir_now, 4);
        chk("t1_no_req", step_req, 0);
        wait_req(n, 1'b1, 30);
        chk("t1_latency", n, 10);
        chk("t1_step_dir", step_dir, 4);
        wait_req(n, 1'b0, 10);
        chk("t1_req_hold", n, 2);
        // Reversal is discarded, next command applies
        press(3'd3);
        press(3'd1);
        wait_req(n, 1'b1, 30);
        chk("t2_reject_dir", step_dir, 4);
        chk("t2_dir_kept", dir_now, 4);
        wait_req(n, 1'b0, 10);
        wait_req(n, 1'b1, 30);
        chk("t2_latency", n, 10);
        chk("t2_turn_dir", step_dir, 1);
        wait_req(n, 1'b0, 10);
        // Fill, overflow, sticky flag
        press(3'd3);
        press(3'd4);
        press(3'd2);
        chk("t3_not_full", fifo_full, 0);
        press(3'd1);
        chk("t3_full", fifo_full, 1);
        chk("t3_no_ovf", overflow, 0);
        press(3'd3);
        chk("t3_ovf", overflow, 1);
        chk("t3_still_full", fifo_full, 1);
        wait_req(n, 1'b1, 30);
        chk("t3_pop1", step_dir, 3);
        wait_req(n, 1'b0, 10);
        wait_req(n, 1'b1, 30);
        chk("t3_pop2_rejected", step_dir, 3);
        wait_req(n, 1'b0, 10);
        wait_req(n, 1'b1, 30);
        chk("t3_pop3", step_dir, 2);
        wait_req(n, 1'b0, 10);
        chk("t3_ovf_sticky", overflow, 1);
        chk("t3_drained", fifo_full, 0);
        // Pause in RUN at counter 6, resume restarts the count
        do_reset();
        chk("t4_ovf_cleared", overflow, 0);
        press(3'd4);
        cyc(6);
        press(3'd5);
        chk("t4_paused", paused, 1);
        press(3'd1);
        quiet(n, 50);
        chk("t4_quiet", n, 0);
        press(3'd5);
        chk("t4_resumed", paused, 0);
        wait_req(n, 1'b1, 30);
        chk("t4_latency", n, 10);
        chk("t4_dir_unchanged", step_dir, 4);
        // Pause during WAIT_ACK takes effect after the ack
        press(3'd5);
        wait_req(n, 1'b0, 10);
        chk("t5_paused_after_ack", paused, 1);
        quiet(n, 30);
        chk("t5_quiet", n, 0);
        press(3'd5);
        chk("t5_resumed", paused, 0);
        // Two pauses during WAIT_ACK cancel
        ack_en = 1'b0;
        wait_req(n, 1'b1, 30);
        press(3'd5);
        press(3'd5);
        ack_en = 1'b1;
        wait_req(n, 1'b0, 10);
        chk("t5_cancel_paused", paused, 0);
        wait_req(n, 1'b1, 30);
        chk("t5_cancel_latency", n, 10);
        wait_req(n, 1'b0, 10);
        // Reset mid-handshake drops step_req
        ack_en = 1'b0;
        wait_req(n, 1'b1, 30);
        reset = 1'b1;
        cyc(1);
        chk("t8_req_dropped", step_req, 0);
        reset = 1'b0;
        ack_en = 1'b1;
        // Enqueue on a full FIFO in the same cycle as a tick pop
        press(3'd4);
        press(3'd1);
        press(3'd3);
        press(3'd2);
        press(3'd4);
        chk("t7_full", fifo_full, 1);
        cyc(5);
        press(3'd3);
        chk("t7_req", step_req, 1);
        chk("t7_step_dir", step_dir, 1);
        chk("t7_full_kept", fifo_full, 1);
        chk("t7_no_drop", overflow, 0);
        wait_req(n, 1'b0, 10);
        wait_req(n, 1'b1, 30);
        chk("t7_next_pop", step_dir, 3);
        wait_req(n, 1'b0, 10);
        // Grow and ignored codes
        do_reset();
        pulse_grow();
        chk("t6_init_grow_ignored", period_now, 10);
        press(3'd6);
        press(3'd7);
        press(3'd0);
        press(3'd5);
        chk("t6_init_ignores", dir_now, 0);
        press(3'd4);
        pulse_grow();
        chk("t6_grow1", period_now, ACCEL ? 7 : 10);
        pulse_grow();
        chk("t6_grow2", period_now, ACCEL ? 5 : 10);
        pulse_grow();
        chk("t6_grow3_floor", period_now, ACCEL ? 5 : 10);
        wait_req(n, 1'b1, 40);
        wait_req(n, 1'b0, 10);
        wait_req(n, 1'b1, 40);
        chk("t6_spacing", n, ACCEL ? 5 : 10);
        wait_req(n, 1'b0, 10);
        cyc(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
